vppm_rx_ctrl: RTL and testbench

Sequencer for the VPPM receive path. It waits for the frequency-detect/median chain to report a stable frequency and derives the demodulator period parameter with a multi-cycle divider. It then enables the demodulator and writes each demodulated bit into the capture RAM at a sequential address. It reports frame completion or one of three fault conditions, and replaces the free-running address counter and the combinational divide in the top level.

---
 rtl/vppm_rx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vppm_rx_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vppm_rx_ctrl.sv
// VPPM receive sequencer: waits for a stable frequency, divides CLK_FREQ by it, then captures demodulated bits to RAM.
// freq_param is valid 34 cycles after capture; each RAM write trails its bit_valid by one cycle; there is no backpressure.
module vppm_rx_ctrl #(
  parameter int NBITS       = 12,
  parameter int CLK_FREQ    = 200000000,
  parameter int FRAME_LEN   = 4096,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MIN_FREQ    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             freq_available,
  input  logic [31:0]      freq_in,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             demod_en,
  output logic [31:0]      freq_param,
  output logic             param_valid,
  output logic             ram_we,
  output logic [NBITS-1:0] ram_addr,
  output logic             ram_din,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       err
);

  localparam logic [31:0]      DIVIDEND = 32'(CLK_FREQ);
  localparam logic [31:0]      MIN_F    = 32'(MIN_FREQ);
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [NBITS-1:0] LAST_IDX = NBITS'(FRAME_LEN - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LOW  = 2'b01;
  localparam logic [1:0] ERR_QUO  = 2'b10;
  localparam logic [1:0] ERR_LOST = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREQ,
    S_DIVIDE,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nxt;
  logic [1:0] err_nxt;
  logic       capture;
  logic       write;

  logic [31:0]      freq_lat;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [5:0]       div_cnt;
  logic [NBITS-1:0] count;
  logic [31:0]      tmo;

  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;
  logic        div_final;
  logic        tmo_hit;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem, quo[31]};
    diff  = trial - {1'b0, freq_lat};
    fits  = ~diff[32];
  end

  assign div_final = (state == S_DIVIDE) && (div_cnt == 6'd33);
  assign tmo_hit   = !bit_valid && (tmo == TMO_LAST);

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    capture   = 1'b0;
    write     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT_FREQ;
      end
      S_WAIT_FREQ: begin
        if (freq_available && (freq_in != 32'd0)) begin
          capture = 1'b1;
          if (freq_in < MIN_F) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_LOW;
          end else begin
            state_nxt = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        if (div_final) begin
          if (quo < 32'd3) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_QUO;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        write = bit_valid;
        // A bit arriving alongside a fault is still written before the abort.
        if (!freq_available || tmo_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_LOST;
        end else if (bit_valid && (count == LAST_IDX)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_nxt = S_WAIT_FREQ;
          err_nxt   = ERR_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      err         <= ERR_NONE;
      busy        <= 1'b0;
      demod_en    <= 1'b0;
      frame_done  <= 1'b0;
      freq_lat    <= 32'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      div_cnt     <= 6'd0;
      freq_param  <= 32'd0;
      param_valid <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= 1'b0;
      count       <= '0;
      tmo         <= 32'd0;
    end else begin
      state      <= state_nxt;
      err        <= err_nxt;
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
      demod_en   <= (state_nxt == S_RUN);
      frame_done <= (state_nxt == S_DONE);

      if (capture) freq_lat <= freq_in;

      // div_cnt 0 loads, 1..32 iterate, 33 publishes the quotient.
      if (state == S_DIVIDE) begin
        div_cnt <= div_cnt + 6'd1;
        if (div_cnt == 6'd0) begin
          rem <= 32'd0;
          quo <= DIVIDEND;
        end else if (div_cnt <= 6'd32) begin
          rem <= fits ? diff[31:0] : trial[31:0];
          quo <= {quo[30:0], fits};
        end
      end else begin
        div_cnt <= 6'd0;
      end

      if ((state_nxt == S_ERROR) || (state_nxt == S_WAIT_FREQ)) begin
        param_valid <= 1'b0;
      end else if (div_final && (quo >= 32'd3)) begin
        freq_param  <= quo - 32'd2;
        param_valid <= 1'b1;
      end

      ram_we <= write;
      if (write) begin
        ram_din  <= bit_data;
        ram_addr <= count;
      end

      if (state != S_RUN) begin
        count <= '0;
      end else if (write) begin
        count <= count + 1'b1;
      end

      if ((state == S_RUN) && !bit_valid) begin
        tmo <= tmo + 32'd1;
      end else begin
        tmo <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_vppm_rx_ctrl.sv
// Directed bench for vppm_rx_ctrl: frame capture, divider latency, fault codes and reset abort.
module tb_vppm_rx_ctrl;

  localparam int NBITS = 4;
  localparam int FLEN  = 8;
  localparam int TMO   = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             freq_available;
  logic [31:0]      freq_in;
  logic             bit_valid;
  logic             bit_data;
  logic             demod_en;
  logic [31:0]      freq_param;
  logic             param_valid;
  logic             ram_we;
  logic [NBITS-1:0] ram_addr;
  logic             ram_din;
  logic             frame_done;
  logic             busy;
  logic [1:0]       err;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  vppm_rx_ctrl #(
    .NBITS(NBITS),
    .CLK_FREQ(200000000),
    .FRAME_LEN(FLEN),
    .TIMEOUT_CYC(TMO),
    .MIN_FREQ(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .freq_available(freq_available),
    .freq_in(freq_in),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .demod_en(demod_en),
    .freq_param(freq_param),
    .param_valid(param_valid),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .frame_done(frame_done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    pat            = 8'b10101010;
    rst            = 1'b1;
    start          = 1'b0;
    freq_available = 1'b0;
    freq_in        = 32'd0;
    bit_valid      = 1'b0;
    bit_data       = 1'b0;
    ticks(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_demod", 32'(demod_en), 32'd0);
    chk("rst_pvalid", 32'(param_valid), 32'd0);
    chk("rst_fparam", freq_param, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);

    // 5 MHz: 200e6/5e6 = 40, param 38, ready 34 edges after capture.
    rst            = 1'b0;
    start          = 1'b1;
    freq_available = 1'b1;
    freq_in        = 32'd5000000;
    ticks(1);
    chk("wait_busy", 32'(busy), 32'd1);
    start = 1'b0;
    ticks(34);
    chk("lat33_pvalid", 32'(param_valid), 32'd0);
    ticks(1);
    chk("lat34_pvalid", 32'(param_valid), 32'd1);
    chk("s1_fparam", freq_param, 32'd38);
    chk("s1_demod", 32'(demod_en), 32'd1);

    for (int i = 0; i < FLEN; i++) begin
      bit_valid = 1'b1;
      bit_data  = pat[7-i];
      ticks(1);
      chk("wr_we", 32'(ram_we), 32'd1);
      chk("wr_addr", 32'(ram_addr), 32'(i));
      chk("wr_din", 32'(ram_din), 32'(pat[7-i]));
      chk("wr_fdone", 32'(frame_done), (i == FLEN - 1) ? 32'd1 : 32'd0);
      bit_valid = 1'b0;
      ticks(1);
      chk("wr_we_off", 32'(ram_we), 32'd0);
    end
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_fdone", 32'(frame_done), 32'd0);
    chk("fin_pvalid", 32'(param_valid), 32'd1);

    // Too-low frequency faults immediately.
    freq_in = 32'd500;
    start   = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(1);
    chk("low_err", 32'(err), 32'd1);
    chk("low_busy", 32'(busy), 32'd0);
    chk("low_demod", 32'(demod_en), 32'd0);
    chk("low_pvalid", 32'(param_valid), 32'd0);
    chk("low_fparam_hold", freq_param, 32'd38);

    freq_in = 32'd10000000;
    start   = 1'b1;
    ticks(1);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    start = 1'b0;
    ticks(35);
    chk("s3_fparam", freq_param, 32'd18);
    chk("s3_pvalid", 32'(param_valid), 32'd1);
    chk("s3_demod", 32'(demod_en), 32'd1);

    // Three writes, then freq lost together with the fourth bit.
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'b0;
      ticks(1);
      bit_valid = 1'b0;
      ticks(1);
    end
    chk("lost_addr2", 32'(ram_addr), 32'd2);
    bit_valid      = 1'b1;
    bit_data       = 1'b1;
    freq_available = 1'b0;
    ticks(1);
    chk("lost_we", 32'(ram_we), 32'd1);
    chk("lost_addr", 32'(ram_addr), 32'd3);
    chk("lost_din", 32'(ram_din), 32'd1);
    chk("lost_err", 32'(err), 32'd3);
    chk("lost_busy", 32'(busy), 32'd0);
    chk("lost_demod", 32'(demod_en), 32'd0);
    bit_valid = 1'b0;
    ticks(1);
    chk("lost_we_off", 32'(ram_we), 32'd0);
    chk("lost_err_hold", 32'(err), 32'd3);

    // Timeout: TMO idle cycles in RUN.
    freq_available = 1'b1;
    freq_in        = 32'd5000000;
    start          = 1'b1;
    ticks(1);
    chk("tmo_clr_err", 32'(err), 32'd0);
    start = 1'b0;
    ticks(35);
    chk("tmo_run", 32'(demod_en), 32'd1);
    ticks(TMO - 1);
    chk("tmo_pre_busy", 32'(busy), 32'd1);
    chk("tmo_pre_err", 32'(err), 32'd0);
    ticks(1);
    chk("tmo_err", 32'(err), 32'd3);
    chk("tmo_busy", 32'(busy), 32'd0);

    // 100 MHz: quotient 2 is rejected.
    freq_in = 32'd100000000;
    start   = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(34);
    chk("q2_pre_busy", 32'(busy), 32'd1);
    ticks(1);
    chk("q2_err", 32'(err), 32'd2);
    chk("q2_pvalid", 32'(param_valid), 32'd0);
    chk("q2_busy", 32'(busy), 32'd0);
    chk("q2_fparam_hold", freq_param, 32'd38);

    // Reset mid-divide.
    freq_in = 32'd5000000;
    start   = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(10);
    rst = 1'b1;
    ticks(1);
    chk("rdiv_busy", 32'(busy), 32'd0);
    chk("rdiv_fparam", freq_param, 32'd0);
    chk("rdiv_err", 32'(err), 32'd0);
    chk("rdiv_pvalid", 32'(param_valid), 32'd0);
    rst   = 1'b0;
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(35);
    chk("r2_pvalid", 32'(param_valid), 32'd1);
    chk("r2_fparam", freq_param, 32'd38);

    // Reset coincident with a bit strobe drops the write.
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    rst       = 1'b1;
    ticks(1);
    chk("rbit_we", 32'(ram_we), 32'd0);
    chk("rbit_demod", 32'(demod_en), 32'd0);
    chk("rbit_fparam", freq_param, 32'd0);
    chk("rbit_addr", 32'(ram_addr), 32'd0);
    bit_valid = 1'b0;
    rst       = 1'b0;
    ticks(1);
    chk("rbit_we_after", 32'(ram_we), 32'd0);
    chk("rbit_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
